// File: rtl/spmv_pkg.sv
// Shared types and constants for the SpMV merge-network datapath.
`ifndef DATA_PRECISION
`define DATA_PRECISION 32
`endif
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 8
`endif

package spmv_pkg;

    typedef logic [`DATA_PRECISION-1:0] data_t;
    typedef logic [`BITS_ROW_IDX-1:0]   row_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        FLUSH = 2'd2
    } issuer_state_e;

    // All-zero IEEE single word, i.e. +0.0, used as the padding operand.
    localparam data_t ZERO_DATA = '0;

endpackage

// File: rtl/adder_pair_issuer_op_reg.sv
// Stall-gated adder operand register plus issue statistics counters.
module adder_op_reg #(
    parameter int DATA_W = `DATA_PRECISION,
    parameter int ROW_W  = `BITS_ROW_IDX,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              issue,
    input  logic              issue_pair,
    input  logic [DATA_W-1:0] issue_in0,
    input  logic [DATA_W-1:0] issue_in1,
    input  logic [ROW_W-1:0]  issue_row,
    output logic              add_valid,
    output logic [DATA_W-1:0] add_in0,
    output logic [DATA_W-1:0] add_in1,
    output logic [ROW_W-1:0]  add_row_idx,
    output logic [CNT_W-1:0]  pair_cnt,
    output logic [CNT_W-1:0]  single_cnt
);

    // Capture the issue decision when downstream can take it; hold everything under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_valid   <= 1'b0;
            add_in0     <= '0;
            add_in1     <= '0;
            add_row_idx <= '0;
            pair_cnt    <= '0;
            single_cnt  <= '0;
        end else if (!stall) begin
            add_valid <= issue;
            if (issue) begin
                add_in0     <= issue_in0;
                add_in1     <= issue_in1;
                add_row_idx <= issue_row;
                if (issue_pair)
                    pair_cnt <= pair_cnt + 1'b1;
                else
                    single_cnt <= single_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_pair_issuer.sv
// Pairs consecutive same-row entries of a row-sorted stream into adder operations.
module adder_pair_issuer
    import spmv_pkg::*;
#(
    parameter int DATA_W = `DATA_PRECISION,
    parameter int ROW_W  = `BITS_ROW_IDX,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ROW_W-1:0]  in_row_idx,
    input  logic              in_last,
    input  logic              stall,
    output logic              add_ena,
    output logic              add_valid,
    output logic [DATA_W-1:0] add_in0,
    output logic [DATA_W-1:0] add_in1,
    output logic [ROW_W-1:0]  add_row_idx,
    output logic [CNT_W-1:0]  pair_cnt,
    output logic [CNT_W-1:0]  single_cnt,
    output logic              order_err
);

    issuer_state_e     state, state_next;
    logic [DATA_W-1:0] h_data, h_data_next;
    logic [ROW_W-1:0]  h_row, h_row_next;
    logic              accept;
    logic              order_hit;
    logic              issue, issue_pair;
    logic [DATA_W-1:0] issue_in0, issue_in1;
    logic [ROW_W-1:0]  issue_row;

    assign in_ready = ~rst & ~stall & (state != FLUSH);
    assign accept   = in_valid & in_ready;
    assign add_ena  = ~stall;

    // State, holding register and sticky order error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            h_data    <= '0;
            h_row     <= '0;
            order_err <= 1'b0;
        end else begin
            state  <= state_next;
            h_data <= h_data_next;
            h_row  <= h_row_next;
            if (order_hit)
                order_err <= 1'b1;
        end
    end

    // Next-state and issue decision; the holding register drives operand 0 by default.
    always_comb begin
        state_next  = state;
        h_data_next = h_data;
        h_row_next  = h_row;
        order_hit   = 1'b0;
        issue       = 1'b0;
        issue_pair  = 1'b0;
        issue_in0   = h_data;
        issue_in1   = '0;
        issue_row   = h_row;
        case (state)
            EMPTY: begin
                if (accept) begin
                    if (in_last) begin
                        issue     = 1'b1;
                        issue_in0 = in_data;
                        issue_row = in_row_idx;
                    end else begin
                        h_data_next = in_data;
                        h_row_next  = in_row_idx;
                        state_next  = HELD;
                    end
                end
            end
            HELD: begin
                if (accept) begin
                    issue = 1'b1;
                    if (in_row_idx == h_row) begin
                        issue_pair = 1'b1;
                        issue_in1  = in_data;
                        state_next = EMPTY;
                    end else begin
                        order_hit   = (in_row_idx < h_row);
                        h_data_next = in_data;
                        h_row_next  = in_row_idx;
                        state_next  = in_last ? FLUSH : HELD;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    issue      = 1'b1;
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    adder_op_reg #(
        .DATA_W(DATA_W),
        .ROW_W (ROW_W),
        .CNT_W (CNT_W)
    ) u_op_reg (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .issue      (issue),
        .issue_pair (issue_pair),
        .issue_in0  (issue_in0),
        .issue_in1  (issue_in1),
        .issue_row  (issue_row),
        .add_valid  (add_valid),
        .add_in0    (add_in0),
        .add_in1    (add_in1),
        .add_row_idx(add_row_idx),
        .pair_cnt   (pair_cnt),
        .single_cnt (single_cnt)
    );

endmodule

// File: tb/tb_adder_pair_issuer.sv
// Directed self-checking bench for adder_pair_issuer.
module tb_adder_pair_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_row_idx;
    logic        in_last;
    logic        stall;
    logic        add_ena;
    logic        add_valid;
    logic [31:0] add_in0;
    logic [31:0] add_in1;
    logic [7:0]  add_row_idx;
    logic [31:0] pair_cnt;
    logic [31:0] single_cnt;
    logic        order_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned exp_pair = 0;
    int unsigned exp_single = 0;

    logic [72:0] op_got;
    logic [72:0] op_exp;

    adder_pair_issuer #(
        .DATA_W(32),
        .ROW_W (8),
        .CNT_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_row_idx (in_row_idx),
        .in_last    (in_last),
        .stall      (stall),
        .add_ena    (add_ena),
        .add_valid  (add_valid),
        .add_in0    (add_in0),
        .add_in1    (add_in1),
        .add_row_idx(add_row_idx),
        .pair_cnt   (pair_cnt),
        .single_cnt (single_cnt),
        .order_err  (order_err)
    );

    always #5 clk = ~clk;

    assign op_got = {add_valid, add_in0, add_in1, add_row_idx};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] row, input logic [31:0] d, input logic last);
        in_valid   = v;
        in_row_idx = row;
        in_data    = d;
        in_last    = last;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        drive(1'b1, 8'd0, 32'h0, 1'b0);
        step();
        step();
        n_cmp++;
        if (op_got !== 73'h0) begin
            n_err++;
            $display("FAIL reset_op: got %h want 0", op_got);
        end
        n_cmp++;
        if ({in_ready, order_err, pair_cnt, single_cnt} !== 66'h0) begin
            n_err++;
            $display("FAIL reset_misc: got rdy=%b err=%b pc=%0d sc=%0d want all 0",
                     in_ready, order_err, pair_cnt, single_cnt);
        end
        drive(1'b0, 8'd0, 32'h0, 1'b0);
        rst = 1'b0;
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || add_ena !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b ena=%b want 1 1", in_ready, add_ena);
        end
    endtask

    task automatic test_pair();
        drive(1'b1, 8'd3, 32'h3F800000, 1'b0);
        step();
        drive(1'b1, 8'd3, 32'h40000000, 1'b1);
        step();
        exp_pair++;
        op_exp = {1'b1, 32'h3F800000, 32'h40000000, 8'd3};
        n_cmp++;
        if (op_got !== op_exp) begin
            n_err++;
            $display("FAIL pair_op: got %h want %h", op_got, op_exp);
        end
        n_cmp++;
        if (pair_cnt !== exp_pair || single_cnt !== exp_single) begin
            n_err++;
            $display("FAIL pair_cnt: got %0d/%0d want %0d/%0d", pair_cnt, single_cnt, exp_pair, exp_single);
        end
        drive(1'b0, 8'd0, 32'h0, 1'b0);
        step();
        n_cmp++;
        if (add_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pair_idle: got valid=%b want 0", add_valid);
        end
    endtask

    task automatic test_row_change();
        drive(1'b1, 8'd5, 32'h0000000A, 1'b0);
        step();
        drive(1'b1, 8'd6, 32'h0000000B, 1'b0);
        step();
        exp_single++;
        op_exp = {1'b1, 32'h0000000A, 32'h0, 8'd5};
        n_cmp++;
        if (op_got !== op_exp) begin
            n_err++;
            $display("FAIL chg_single: got %h want %h", op_got, op_exp);
        end
        drive(1'b1, 8'd6, 32'h0000000C, 1'b1);
        step();
        exp_pair++;
        op_exp = {1'b1, 32'h0000000B, 32'h0000000C, 8'd6};
        n_cmp++;
        if (op_got !== op_exp) begin
            n_err++;
            $display("FAIL chg_pair: got %h want %h", op_got, op_exp);
        end
        drive(1'b0, 8'd0, 32'h0, 1'b0);
        step();
        n_cmp++;
        if (add_valid !== 1'b0 || in_ready !== 1'b1 || pair_cnt !== exp_pair || single_cnt !== exp_single) begin
            n_err++;
            $display("FAIL chg_end: got v=%b rdy=%b pc=%0d sc=%0d want 0 1 %0d %0d",
                     add_valid, in_ready, pair_cnt, single_cnt, exp_pair, exp_single);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 8'd7, 32'h11111111, 1'b0);
        step();
        drive(1'b1, 8'd8, 32'h22222222, 1'b1);
        step();
        exp_single++;
        op_exp = {1'b1, 32'h11111111, 32'h0, 8'd7};
        drive(1'b0, 8'd0, 32'h0, 1'b0);
        n_cmp++;
        if (op_got !== op_exp || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_first: got %h rdy=%b want %h rdy=0", op_got, in_ready, op_exp);
        end
        step();
        exp_single++;
        op_exp = {1'b1, 32'h22222222, 32'h0, 8'd8};
        n_cmp++;
        if (op_got !== op_exp || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_second: got %h rdy=%b want %h rdy=1", op_got, in_ready, op_exp);
        end
        n_cmp++;
        if (single_cnt !== exp_single || pair_cnt !== exp_pair) begin
            n_err++;
            $display("FAIL flush_cnt: got %0d/%0d want %0d/%0d", pair_cnt, single_cnt, exp_pair, exp_single);
        end
        step();
    endtask

    task automatic test_back_to_back_stall();
        drive(1'b1, 8'd2, 32'h0000AAAA, 1'b0);
        step();
        drive(1'b1, 8'd2, 32'h0000BBBB, 1'b1);
        step();
        exp_pair++;
        op_exp = {1'b1, 32'h0000AAAA, 32'h0000BBBB, 8'd2};
        stall = 1'b1;
        drive(1'b1, 8'd10, 32'h0000DDDD, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || add_ena !== 1'b0) begin
                n_err++;
                $display("FAIL stall_ctrl[%0d]: got rdy=%b ena=%b want 0 0", i, in_ready, add_ena);
            end
            step();
            n_cmp++;
            if (op_got !== op_exp || pair_cnt !== exp_pair || single_cnt !== exp_single) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %h pc=%0d sc=%0d want %h %0d %0d",
                         i, op_got, pair_cnt, single_cnt, op_exp, exp_pair, exp_single);
            end
        end
        stall = 1'b0;
        step();
        exp_single++;
        op_exp = {1'b1, 32'h0000DDDD, 32'h0, 8'd10};
        n_cmp++;
        if (op_got !== op_exp || single_cnt !== exp_single) begin
            n_err++;
            $display("FAIL stall_release: got %h sc=%0d want %h %0d", op_got, single_cnt, op_exp, exp_single);
        end
        drive(1'b0, 8'd0, 32'h0, 1'b0);
        step();
    endtask

    task automatic test_order_err();
        drive(1'b1, 8'd9, 32'h00000009, 1'b0);
        step();
        n_cmp++;
        if (order_err !== 1'b0) begin
            n_err++;
            $display("FAIL order_pre: got %b want 0", order_err);
        end
        drive(1'b1, 8'd4, 32'h00000004, 1'b0);
        step();
        exp_single++;
        op_exp = {1'b1, 32'h00000009, 32'h0, 8'd9};
        n_cmp++;
        if (op_got !== op_exp || order_err !== 1'b1) begin
            n_err++;
            $display("FAIL order_set: got %h err=%b want %h err=1", op_got, order_err, op_exp);
        end
        drive(1'b0, 8'd0, 32'h0, 1'b0);
        step();
        drive(1'b1, 8'd4, 32'h00000005, 1'b1);
        step();
        exp_pair++;
        op_exp = {1'b1, 32'h00000004, 32'h00000005, 8'd4};
        n_cmp++;
        if (op_got !== op_exp || order_err !== 1'b1) begin
            n_err++;
            $display("FAIL order_held: got %h err=%b want %h err=1", op_got, order_err, op_exp);
        end
        drive(1'b0, 8'd0, 32'h0, 1'b0);
        step();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'd1, 32'h0000F00D, 1'b0);
        step();
        drive(1'b0, 8'd0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (op_got !== 73'h0 || pair_cnt !== 32'd0 || single_cnt !== 32'd0 || order_err !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst: got op=%h pc=%0d sc=%0d err=%b rdy=%b want all 0",
                     op_got, pair_cnt, single_cnt, order_err, in_ready);
        end
        step();
        rst = 1'b0;
        exp_pair = 0;
        exp_single = 0;
        step();
        drive(1'b1, 8'd1, 32'h0000BEEF, 1'b1);
        step();
        exp_single++;
        op_exp = {1'b1, 32'h0000BEEF, 32'h0, 8'd1};
        n_cmp++;
        if (op_got !== op_exp || pair_cnt !== exp_pair || single_cnt !== exp_single) begin
            n_err++;
            $display("FAIL post_rst: got %h pc=%0d sc=%0d want %h %0d %0d",
                     op_got, pair_cnt, single_cnt, op_exp, exp_pair, exp_single);
        end
        drive(1'b0, 8'd0, 32'h0, 1'b0);
        step();
        n_cmp++;
        if (add_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_rst_idle: got v=%b rdy=%b want 0 1", add_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_row_change();
        test_flush();
        test_back_to_back_stall();
        test_order_err();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_pair_issuer.md
Name: adder_pair_issuer

Overview:
- Front end of the merge-network adder stage.
- Accepts a row-sorted stream of (row_idx, value) partial products.
- Pairs consecutive same-row entries and issues them to the registered-input adder as operand0/operand1, together with valid, row index and enable.
- A lone entry of a row is padded with operand1 = 0, so every row leaves the issuer as one or more adder operations.

Parameters:
- DATA_W, `DATA_PRECISION, operand width (IEEE single; all-zero word = +0.0).
- ROW_W, `BITS_ROW_IDX, row index width.
- CNT_W, 32, width of the issue statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input entry valid.
- in_ready  out  1  issuer accepts the entry this cycle.
- in_data  in  DATA_W  entry value.
- in_row_idx  in  ROW_W  entry row.
- in_last  in  1  entry is the final one of the stream.
- stall  in  1  downstream cannot take a new adder operation.
- add_ena  out  1  enable to the adder input registers (= ~stall).
- add_valid  out  1  operation valid (adder data_valid).
- add_in0  out  DATA_W  operand 0.
- add_in1  out  DATA_W  operand 1.
- add_row_idx  out  ROW_W  operation row.
- pair_cnt  out  CNT_W  operations issued with two real operands.
- single_cnt  out  CNT_W  operations issued with zero padding.
- order_err  out  1  sticky: input row index decreased.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: every output register 0, holding register empty, state EMPTY, in_ready 0 during reset.
- Accept: entry accepted when in_valid & in_ready.
- in_ready = ~stall & (state != FLUSH).
- Output registers (add_valid/in0/in1/row_idx) update only when ~stall. While stall=1 they hold value, including add_valid=1.
- Latency: an issue decided in cycle t is visible on the add_* outputs from cycle t+1.
- A cycle with ~stall and no issue drives add_valid=0 on the next cycle.
- Holding register H = {data, row}.
- EMPTY, accepted entry e:
  - in_last=0: H<=e, go HELD.
  - in_last=1: issue (e.data, 0, e.row), stay EMPTY.
- HELD, accepted entry e:
  - e.row==H.row: issue (H.data, e.data, H.row), go EMPTY. in_last is irrelevant here.
  - e.row!=H.row, in_last=0: issue (H.data, 0, H.row), H<=e, stay HELD.
  - e.row!=H.row, in_last=1: issue (H.data, 0, H.row), H<=e, go FLUSH.
- HELD, no entry accepted: nothing issued, H kept indefinitely. Only a following entry or in_last releases it.
- FLUSH: when ~stall, issue (H.data, 0, H.row), go EMPTY. in_ready=0 throughout FLUSH.
- Arithmetic: row compare is plain unsigned equality. Values are passed through untouched, never added here.
- Counters: pair_cnt/single_cnt increment on the cycle an issue is registered; they wrap at 2^CNT_W.
- order_err: set when an accepted entry has e.row < H.row in HELD. Cleared only by reset. The entry is still processed as "different row".
- Stall on the same cycle as a would-be issue: in_ready=0, so there is no accept and no state change. The decision repeats when stall drops.
- Reset asserted mid-stream: H, state, outputs and counters cleared immediately. A partially held row is discarded.

Decomposition:
- Shared package spmv_pkg:
  - typedef data_t = logic[`DATA_PRECISION-1:0].
  - typedef row_t = logic[`BITS_ROW_IDX-1:0].
  - typedef issuer_state_e = {EMPTY, HELD, FLUSH}.
  - constant ZERO_DATA = '0.
- One natural sub-module: adder_op_reg. It is the stall-gated output register for {valid, in0, in1, row_idx} plus the counter increments. The FSM/holding logic stays in the top.

Test Plan:
- Rows 3,3 (vals 0x3F800000, 0x40000000), last on second, stall=0 → one cycle later add_valid=1, in0=0x3F800000, in1=0x40000000, row=3; pair_cnt=1.
- Rows 5,6,6(last), values A,B,C → issues (A,0,5) then (B,C,6); single_cnt=1, pair_cnt=1, final state EMPTY.
- Rows 7,8(last), values A,B → (A,0,7), FLUSH with in_ready=0 one cycle, then (B,0,8); single_cnt=2.
- Stall held 3 cycles while add_valid=1 for (A,B,2) → outputs unchanged, in_ready=0, add_ena=0, counters unchanged; on release the next op issues one cycle later.
- Rows 9 then 4 → order_err=1 and stays 1; issue (v9,0,9); 4 held as a new row.
- Rst pulsed asynchronously while in HELD with row 1 → all outputs 0 immediately; a subsequent row 1 (last) issues (v,0,1) only.
